// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request and register-file write-port bundle.
// Slave side is the arbiter; master side drives the two sources.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADR_W  = 3
);
  logic              req0_valid;
  logic [ADR_W-1:0]  req0_adr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADR_W-1:0]  req1_adr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [ADR_W-1:0]  W_Adr;
  logic              we;
  logic [DATA_W-1:0] W;
  logic              grant1;
  logic              busy;

  modport slave (
    input  req0_valid, req0_adr, req0_data,
    input  req1_valid, req1_adr, req1_data,
    output req0_ready, req1_ready,
    output W_Adr, we, W, grant1, busy
  );

  modport master (
    output req0_valid, req0_adr, req0_data,
    output req1_valid, req1_adr, req1_data,
    input  req0_ready, req1_ready,
    input  W_Adr, we, W, grant1, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the 8x16 register file write port.
// WB_ARB_RR_EN selects round-robin; otherwise source 0 has fixed priority.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADR_W  = 3
) (
  input logic clk,
  input logic reset,
  regfile_wb_arbiter_if.slave bus
);

  logic              full0_q, full0_d;
  logic              full1_q, full1_d;
  logic [ADR_W-1:0]  adr0_q, adr0_d;
  logic [ADR_W-1:0]  adr1_q, adr1_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic              we_q, we_d;
  logic [ADR_W-1:0]  w_adr_q, w_adr_d;
  logic [DATA_W-1:0] w_q, w_d;
  logic              grant1_q, grant1_d;
  logic              g0, g1;
  logic              acc0, acc1;
`ifdef WB_ARB_RR_EN
  logic              ptr_q, ptr_d;
`endif

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
`ifdef WB_ARB_RR_EN
    if (full0_q && full1_q) begin
      g0 = ~ptr_q;
      g1 = ptr_q;
    end else begin
      g0 = full0_q;
      g1 = full1_q;
    end
`else
    g0 = full0_q;
    g1 = full1_q & ~full0_q;
`endif
  end

  // A buffer being granted can take a new entry on the same edge.
  assign bus.req0_ready = ~full0_q | g0;
  assign bus.req1_ready = ~full1_q | g1;
  assign acc0 = bus.req0_valid & bus.req0_ready;
  assign acc1 = bus.req1_valid & bus.req1_ready;

  always_comb begin
    full0_d  = acc0 | (full0_q & ~g0);
    full1_d  = acc1 | (full1_q & ~g1);
    adr0_d   = acc0 ? bus.req0_adr  : adr0_q;
    data0_d  = acc0 ? bus.req0_data : data0_q;
    adr1_d   = acc1 ? bus.req1_adr  : adr1_q;
    data1_d  = acc1 ? bus.req1_data : data1_q;
    we_d     = g0 | g1;
    w_adr_d  = w_adr_q;
    w_d      = w_q;
    grant1_d = grant1_q;
    unique case (1'b1)
      g0: begin
        w_adr_d  = adr0_q;
        w_d      = data0_q;
        grant1_d = 1'b0;
      end
      g1: begin
        w_adr_d  = adr1_q;
        w_d      = data1_q;
        grant1_d = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef WB_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (g0) ptr_d = 1'b1;
    else if (g1) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full0_q  <= 1'b0;
      full1_q  <= 1'b0;
      adr0_q   <= '0;
      adr1_q   <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
      we_q     <= 1'b0;
      w_adr_q  <= '0;
      w_q      <= '0;
      grant1_q <= 1'b0;
    end else begin
      full0_q  <= full0_d;
      full1_q  <= full1_d;
      adr0_q   <= adr0_d;
      adr1_q   <= adr1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      we_q     <= we_d;
      w_adr_q  <= w_adr_d;
      w_q      <= w_d;
      grant1_q <= grant1_d;
    end
  end

  assign bus.we     = we_q;
  assign bus.W_Adr  = w_adr_q;
  assign bus.W      = w_q;
  assign bus.grant1 = grant1_q;
  assign bus.busy   = full0_q | full1_q | we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter.
// Expected grant order is queued at stimulus time and popped on each we.
module tb_regfile_wb_arbiter;
  localparam int DW = 16;
  localparam int AW = 3;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADR_W(AW)) bus ();

  regfile_wb_arbiter #(.DATA_W(DW), .ADR_W(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  wr_t q0[$];
  wr_t q1[$];
  bit  gq[$];
  int  n_cmp;
  int  n_fail;
  int  n_we;
  logic [DW-1:0] rf [8];

  task automatic monitor();
    wr_t e;
    bit  src;
    forever begin
      @(negedge clk);
      if (bus.we === 1'b1) begin
        n_we++;
        rf[bus.W_Adr] = bus.W;
        n_cmp++;
        if (gq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: W_Adr=%0d W=%h, none expected",
                   bus.W_Adr, bus.W);
        end else begin
          src = gq.pop_front();
          if (bus.grant1 !== src) begin
            n_fail++;
            $display("FAIL grant_src: got %b want %b", bus.grant1, src);
          end
          if ((src ? q1.size() : q0.size()) == 0) begin
            n_fail++;
            $display("FAIL sb_empty: src %0d got %0d/%h, no entry",
                     src, bus.W_Adr, bus.W);
          end else begin
            e = src ? q1.pop_front() : q0.pop_front();
            n_cmp++;
            if ({bus.W_Adr, bus.W} !== e) begin
              n_fail++;
              $display("FAIL write_data: got %0d/%h want %0d/%h",
                       bus.W_Adr, bus.W, e.adr, e.data);
            end
          end
        end
      end
    end
  endtask

  task automatic clear_sb();
    q0.delete();
    q1.delete();
    gq.delete();
  endtask

  // Drives one cycle of requests; called #1 after a rising edge.
  task automatic step(input bit v0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input bit v1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.req0_valid = v0;
    bus.req0_adr   = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_adr   = a1;
    bus.req1_data  = d1;
    if (v0 && bus.req0_ready === 1'b1) q0.push_back({a0, d0});
    if (v1 && bus.req1_ready === 1'b1) q1.push_back({a1, d1});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_sb();
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 40; k++) begin
      if (gq.size() == 0 && bus.we === 1'b0) break;
      idle();
    end
    n_cmp++;
    if (k == 40) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d grants still pending, want 0",
               gq.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.W_Adr, bus.W, bus.we, bus.grant1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: adr=%0d W=%h we=%b g1=%b want 0",
               bus.W_Adr, bus.W, bus.we, bus.grant1);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_ready: rdy0=%b rdy1=%b busy=%b want 1 1 0",
               bus.req0_ready, bus.req1_ready, bus.busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    do_reset();
    gq.push_back(1'b0);
    step(1, 3'd3, 16'hBEEF, 0, '0, '0);
    n_cmp++;
    if (bus.we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: we=%b want 0", bus.we);
    end
    idle();
    n_cmp++;
    if ({bus.we, bus.W_Adr, bus.W, bus.grant1} !== {1'b1, 3'd3, 16'hBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL single_write: we=%b adr=%0d W=%h g1=%b want 1 3 beef 0",
               bus.we, bus.W_Adr, bus.W, bus.grant1);
    end
    idle();
    n_cmp++;
    if ({bus.we, bus.W_Adr, bus.W, bus.busy} !== {1'b0, 3'd3, 16'hBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL single_after: we=%b adr=%0d W=%h busy=%b want 0 3 beef 0",
               bus.we, bus.W_Adr, bus.W, bus.busy);
    end
  endtask

  task automatic test_contention();
    do_reset();
    gq.push_back(1'b0);
    gq.push_back(1'b1);
    step(1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222);
    idle();
    n_cmp++;
    if ({bus.we, bus.W_Adr} !== {1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL cont_first: we=%b adr=%0d want 1 1", bus.we, bus.W_Adr);
    end
    idle();
    n_cmp++;
    if ({bus.we, bus.W_Adr, bus.grant1} !== {1'b1, 3'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL cont_second: we=%b adr=%0d g1=%b want 1 2 1",
               bus.we, bus.W_Adr, bus.grant1);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    bit r0, r1;
    int we0;
    do_reset();
    we0 = n_we;
`ifdef WB_ARB_RR_EN
    for (int k = 0; k < 9; k++) gq.push_back(k[0]);
`else
    for (int k = 0; k < 8; k++) gq.push_back(1'b0);
    gq.push_back(1'b1);
`endif
    for (int i = 0; i < 8; i++) begin
`ifdef WB_ARB_RR_EN
      r0 = (i == 0) || i[0];
      r1 = (i == 0) || !i[0];
`else
      r0 = 1'b1;
      r1 = (i == 0);
`endif
      n_cmp++;
      if ({bus.req0_ready, bus.req1_ready} !== {r0, r1}) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: rdy0=%b rdy1=%b want %b %b",
                 i, bus.req0_ready, bus.req1_ready, r0, r1);
      end
      step(1, AW'(i), 16'hA000 | DW'(i), 1, AW'(7 - i), 16'hB000 | DW'(i));
    end
    idle();
    wait_drain();
    n_cmp++;
    if (n_we - we0 != 9) begin
      n_fail++;
      $display("FAIL b2b_count: %0d writes want 9", n_we - we0);
    end
  endtask

  task automatic test_same_addr();
    int we0;
    do_reset();
    rf[5] = '0;
    we0 = n_we;
    gq.push_back(1'b0);
    gq.push_back(1'b1);
    step(1, 3'd5, 16'hAAAA, 1, 3'd5, 16'h5555);
    idle();
    wait_drain();
    n_cmp++;
    if (n_we - we0 != 2 || rf[5] !== 16'h5555) begin
      n_fail++;
      $display("FAIL same_addr: %0d writes reg5=%h want 2 5555",
               n_we - we0, rf[5]);
    end
  endtask

  task automatic test_reset_mid();
    int we0;
    do_reset();
    we0 = n_we;
    step(0, '0, '0, 1, 3'd7, 16'h7777);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.we, bus.busy, bus.req0_ready, bus.req1_ready} !== 4'b0011) begin
      n_fail++;
      $display("FAIL mid_reset: we=%b busy=%b rdy=%b%b want 0 0 11",
               bus.we, bus.busy, bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_sb();
    repeat (4) idle();
    n_cmp++;
    if (n_we != we0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_discard: %0d writes busy=%b want 0 0",
               n_we - we0, bus.busy);
    end
    step(1, 3'd4, 16'h4444, 0, '0, '0);
    idle();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.we !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_we_drop: we=%b want 0", bus.we);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_sb();
    idle();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    n_we   = 0;
    reset  = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_adr   = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_adr   = '0;
    bus.req1_data  = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_same_addr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
